pd_m1_pwr_seq: RTL

//  Power sequencer for PD_M1, the less-on domain that drives the Stage1 side of in_TimingEngine.

---
 rtl/pd_m1_pwr_seq.sv | 102 ++++++++++
 1 files changed

// File: rtl/pd_m1_pwr_seq.sv
// pd_m1_pwr_seq: power sequencer ordering isolation, retention, power switch and reset for PD_M1
// Ports:
//   ck_i/arst_i        clock, synchronous active-high reset
//   pwrDownReq_i       level request to power down (sampled in ON)
//   pwrUpReq_i         level request to power up (sampled in OFF)
//   pswAckM1_i         power switch status from PD_M1 (1 = powered)
//   errClr_i           clears errTimeout_o
//   isolateM1M2_o      clamp for M1->M2 SVI signals
//   retainM1_o         retention save/hold
//   pswEnM1_o          power switch enable
//   rstHoldM1_o        holds M1 logic in reset
//   m1On_o / busy_o    idle-on indication / sequencing in progress
//   errTimeout_o       sticky switch-ack timeout flag
module pd_m1_pwr_seq #(
  parameter int ISO_SETUP = 2,
  parameter int RST_HOLD  = 4,
  parameter int ACK_TMO   = 64
) (
  input  logic ck_i,
  input  logic arst_i,
  input  logic pwrDownReq_i,
  input  logic pwrUpReq_i,
  input  logic pswAckM1_i,
  input  logic errClr_i,
  output logic isolateM1M2_o,
  output logic retainM1_o,
  output logic pswEnM1_o,
  output logic rstHoldM1_o,
  output logic m1On_o,
  output logic busy_o,
  output logic errTimeout_o
);
  localparam int MX_A = (ISO_SETUP > RST_HOLD) ? ISO_SETUP : RST_HOLD;
  localparam int MX   = (MX_A > ACK_TMO) ? MX_A : ACK_TMO;
  localparam int CW   = $clog2(MX) + 1;
  // RST_REL counts RST_HOLD down to 0 so its final cycle releases reset while still isolated
  localparam logic [CW-1:0] ISO_LD = CW'(ISO_SETUP - 1);
  localparam logic [CW-1:0] RH_LD  = CW'(RST_HOLD);
  localparam logic [CW-1:0] TMO_LD = CW'(ACK_TMO - 1);

  typedef enum logic [2:0] {
    OFF, PSW_ON, RST_REL, DE_ISO, ON, ISO_ON, RET, PSW_OFF
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic tmo;
  logic iso_q, ret_q, psw_q, rh_q, on_q, busy_q, err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    tmo     = 1'b0;
    case (state_q)
      OFF:     if (pwrUpReq_i) begin state_d = PSW_ON; cnt_d = TMO_LD; end
      PSW_ON:  if (pswAckM1_i) begin state_d = RST_REL; cnt_d = RH_LD; end
               else if (cnt_q == '0) begin state_d = OFF; tmo = 1'b1; end
      RST_REL: if (cnt_q == '0) begin state_d = DE_ISO; cnt_d = ISO_LD; end
      DE_ISO:  if (cnt_q == '0) state_d = ON;
      ON:      if (pwrDownReq_i) begin state_d = ISO_ON; cnt_d = ISO_LD; end
      ISO_ON:  if (cnt_q == '0) state_d = RET;
      RET:     begin state_d = PSW_OFF; cnt_d = TMO_LD; end
      PSW_OFF: if (!pswAckM1_i) state_d = OFF;
               else if (cnt_q == '0) begin state_d = OFF; tmo = 1'b1; end
      default: state_d = OFF;
    endcase
  end

  // outputs are decoded from the current state register, so they trail the state by one cycle
  always_ff @(posedge ck_i) begin
    if (arst_i) begin
      state_q <= OFF;
      cnt_q   <= '0;
      iso_q   <= 1'b1;
      ret_q   <= 1'b0;
      psw_q   <= 1'b0;
      rh_q    <= 1'b1;
      on_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iso_q   <= !(state_q == DE_ISO || state_q == ON);
      ret_q   <= (state_q == RET) ? 1'b1 : (state_q == RST_REL) ? 1'b0 : ret_q;
      psw_q   <= !(state_q == OFF || state_q == PSW_OFF);
      rh_q    <= state_q == OFF || state_q == PSW_ON || state_q == PSW_OFF ||
                 (state_q == RST_REL && cnt_q != '0);
      on_q    <= state_q == ON;
      busy_q  <= !(state_q == ON || state_q == OFF);
      err_q   <= tmo ? 1'b1 : errClr_i ? 1'b0 : err_q;
    end
  end

  assign isolateM1M2_o = iso_q;
  assign retainM1_o    = ret_q;
  assign pswEnM1_o     = psw_q;
  assign rstHoldM1_o   = rh_q;
  assign m1On_o        = on_q;
  assign busy_o        = busy_q;
  assign errTimeout_o  = err_q;
endmodule
